// File: rtl/fifomult_driver.sv
// Initiator for the fifomult operand/result protocol: sends A then B with parity, awaits the result.
// Optional FIFOMULT_DRV_CHECK_EN adds a reference product and drives rsp_mismatch.
//
// state    | meaning
// IDLE     | cmd_ready high, waiting for a host command
// SEND_A   | strobe operand A once busy_out is low
// GAP_A    | mandatory idle cycle after the A strobe
// SEND_B   | strobe operand B once busy_out is low
// GAP_B    | idle cycle after the B strobe, clears the timeout counter
// WAIT_RES | waiting for data_out_valid or timeout expiry
// RESP     | response held until rsp_ready
module fifomult_driver #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    input  logic        cmd_bad_parity_a,
    input  logic        cmd_bad_parity_b,
    output logic [15:0] data_in,
    output logic        data_in_parity,
    output logic        data_in_valid,
    input  logic        busy_out,
    input  logic [31:0] data_out,
    input  logic        data_out_parity,
    input  logic        data_out_valid,
    input  logic        data_in_parity_error,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_in_parity_error,
    output logic        rsp_out_parity_error,
    output logic        rsp_timeout,
    output logic        rsp_mismatch
);

    typedef enum logic [2:0] {
        IDLE, SEND_A, GAP_A, SEND_B, GAP_B, WAIT_RES, RESP
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] a_q, b_q;
    logic        bad_a_q, bad_b_q;
    logic [15:0] data_in_q;
    logic        data_in_parity_q;
    logic        data_in_valid_q;
    logic [15:0] cnt_q;
    logic [31:0] rsp_data_q;
    logic        rsp_in_pe_q, rsp_out_pe_q, rsp_timeout_q;
    logic        timeout_hit;

    assign timeout_hit = (cnt_q == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (cmd_valid)                     state_d = SEND_A;
            SEND_A:   if (!busy_out)                     state_d = GAP_A;
            GAP_A:                                       state_d = SEND_B;
            SEND_B:   if (!busy_out)                     state_d = GAP_B;
            GAP_B:                                       state_d = WAIT_RES;
            WAIT_RES: if (data_out_valid || timeout_hit) state_d = RESP;
            RESP:     if (rsp_ready)                     state_d = IDLE;
            default:                                     state_d = IDLE;
        endcase
    end

    // cmd_ready is gated by rst so the host never sees it during reset.
    always_comb begin
        cmd_ready = (state_q == IDLE) && !rst;
        rsp_valid = (state_q == RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q              <= '0;
            b_q              <= '0;
            bad_a_q          <= 1'b0;
            bad_b_q          <= 1'b0;
            data_in_q        <= '0;
            data_in_parity_q <= 1'b0;
            data_in_valid_q  <= 1'b0;
            cnt_q            <= '0;
            rsp_data_q       <= '0;
            rsp_in_pe_q      <= 1'b0;
            rsp_out_pe_q     <= 1'b0;
            rsp_timeout_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        a_q     <= cmd_a;
                        b_q     <= cmd_b;
                        bad_a_q <= cmd_bad_parity_a;
                        bad_b_q <= cmd_bad_parity_b;
                    end
                end
                SEND_A: begin
                    data_in_valid_q <= !busy_out;
                    if (!busy_out) begin
                        data_in_q        <= a_q;
                        data_in_parity_q <= (^a_q) ^ bad_a_q;
                    end
                end
                SEND_B: begin
                    data_in_valid_q <= !busy_out;
                    if (!busy_out) begin
                        data_in_q        <= b_q;
                        data_in_parity_q <= (^b_q) ^ bad_b_q;
                    end
                end
                GAP_A: data_in_valid_q <= 1'b0;
                GAP_B: begin
                    data_in_valid_q <= 1'b0;
                    cnt_q           <= '0;
                end
                WAIT_RES: begin
                    cnt_q <= cnt_q + 16'd1;
                    // A result arriving on the expiry cycle takes priority.
                    if (data_out_valid) begin
                        rsp_data_q    <= data_out;
                        rsp_in_pe_q   <= data_in_parity_error;
                        rsp_out_pe_q  <= (^data_out) != data_out_parity;
                        rsp_timeout_q <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_data_q    <= '0;
                        rsp_in_pe_q   <= 1'b0;
                        rsp_out_pe_q  <= 1'b0;
                        rsp_timeout_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FIFOMULT_DRV_CHECK_EN
    logic signed [31:0] product_q;
    logic               rsp_mismatch_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            product_q      <= '0;
            rsp_mismatch_q <= 1'b0;
        end else begin
            if (state_q == SEND_A) product_q <= $signed(a_q) * $signed(b_q);
            if (state_q == WAIT_RES) begin
                if (data_out_valid)
                    rsp_mismatch_q <= (data_out != product_q) && !data_in_parity_error;
                else if (timeout_hit)
                    rsp_mismatch_q <= 1'b0;
            end
        end
    end

    assign rsp_mismatch = rsp_mismatch_q;
`else
    assign rsp_mismatch = 1'b0;
`endif

    assign data_in              = data_in_q;
    assign data_in_parity       = data_in_parity_q;
    assign data_in_valid        = data_in_valid_q;
    assign rsp_data             = rsp_data_q;
    assign rsp_in_parity_error  = rsp_in_pe_q;
    assign rsp_out_parity_error = rsp_out_pe_q;
    assign rsp_timeout          = rsp_timeout_q;

endmodule

// File: tb/tb_fifomult_driver.sv
// Scoreboard bench for fifomult_driver: operand and response queues checked by negedge monitors.
module tb_fifomult_driver;

    localparam int TO = 16;
`ifdef FIFOMULT_DRV_CHECK_EN
    localparam logic CHK_EN = 1'b1;
`else
    localparam logic CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [15:0] cmd_a, cmd_b;
    logic        cmd_bad_parity_a, cmd_bad_parity_b;
    logic [15:0] data_in;
    logic        data_in_parity, data_in_valid;
    logic        busy_out;
    logic [31:0] data_out;
    logic        data_out_parity, data_out_valid, data_in_parity_error;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_in_parity_error, rsp_out_parity_error, rsp_timeout, rsp_mismatch;

    always #5 clk = ~clk;

    fifomult_driver #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_bad_parity_a(cmd_bad_parity_a), .cmd_bad_parity_b(cmd_bad_parity_b),
        .data_in(data_in), .data_in_parity(data_in_parity), .data_in_valid(data_in_valid),
        .busy_out(busy_out),
        .data_out(data_out), .data_out_parity(data_out_parity), .data_out_valid(data_out_valid),
        .data_in_parity_error(data_in_parity_error),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_in_parity_error(rsp_in_parity_error), .rsp_out_parity_error(rsp_out_parity_error),
        .rsp_timeout(rsp_timeout), .rsp_mismatch(rsp_mismatch)
    );

    typedef struct { logic [15:0] d; logic p; } op_t;
    typedef struct { logic [31:0] data; logic ipe; logic ope; logic to; logic mm; } rsp_t;

    op_t  op_q[$];
    rsp_t rsp_q[$];
    int   strobe_cyc_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_strobe = -100;
    logic busy_smp = 1'b0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        busy_smp <= busy_out;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Operand monitor: every strobe must match the next queued operand.
    always @(negedge clk) begin
        if (data_in_valid === 1'b1) begin
            op_t e;
            check("strobe_not_while_busy", {31'd0, busy_smp}, 32'd0);
            check("strobe_gap_ge_2", {31'd0, (cyc - last_strobe) >= 2}, 32'd1);
            last_strobe = cyc;
            strobe_cyc_q.push_back(cyc);
            if (op_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_strobe: got data_in %h, expected no strobe", data_in);
            end else begin
                e = op_q.pop_front();
                check("operand", {16'd0, data_in}, {16'd0, e.d});
                check("operand_parity", {31'd0, data_in_parity}, {31'd0, e.p});
            end
        end
    end

    // Response monitor: fires on the cycle before each accepting edge.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            rsp_t e;
            if (rsp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got rsp_data %h, expected no response", rsp_data);
            end else begin
                e = rsp_q.pop_front();
                check("rsp_data", rsp_data, e.data);
                check("rsp_in_parity_error", {31'd0, rsp_in_parity_error}, {31'd0, e.ipe});
                check("rsp_out_parity_error", {31'd0, rsp_out_parity_error}, {31'd0, e.ope});
                check("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.to});
                check("rsp_mismatch", {31'd0, rsp_mismatch}, {31'd0, e.mm});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rsp(input logic [31:0] d, input logic ipe, ope, to, mm);
        rsp_q.push_back(rsp_t'{data: d, ipe: ipe, ope: ope, to: to, mm: mm});
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic bpa, input logic bpb, output int c0);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("cmd_ready_before_issue", {31'd0, cmd_ready}, 32'd1);
        op_q.push_back(op_t'{d: a, p: (^a) ^ bpa});
        op_q.push_back(op_t'{d: b, p: (^b) ^ bpb});
        strobe_cyc_q.delete();
        cmd_a = a;
        cmd_b = b;
        cmd_bad_parity_a = bpa;
        cmd_bad_parity_b = bpb;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_b_strobe();
        int cnt = 0;
        int n = 0;
        while (cnt < 2 && n < 100) begin
            tick();
            n++;
            if (data_in_valid === 1'b1) cnt++;
        end
        check("both_strobes_seen", cnt, 2);
    endtask

    task automatic respond(input logic [31:0] d, input logic par, input logic ipe, input int delay);
        repeat (delay) tick();
        data_out = d;
        data_out_parity = par;
        data_in_parity_error = ipe;
        data_out_valid = 1'b1;
        tick();
        data_out_valid = 1'b0;
        data_in_parity_error = 1'b0;
    endtask

    task automatic check_latency(input int c0, input int da, input int db);
        if (strobe_cyc_q.size() < 2) begin
            tests++;
            fails++;
            $display("FAIL strobe_latency: got %0d strobes, expected 2", strobe_cyc_q.size());
        end else begin
            check("a_strobe_latency", strobe_cyc_q[0] - c0, da);
            check("b_strobe_latency", strobe_cyc_q[1] - c0, db);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int n;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0;
        cmd_bad_parity_a = 1'b0; cmd_bad_parity_b = 1'b0;
        busy_out = 1'b0; data_out = '0; data_out_parity = 1'b0;
        data_out_valid = 1'b0; data_in_parity_error = 1'b0; rsp_ready = 1'b1;

        repeat (3) tick();
        check("cmd_ready_in_reset", {31'd0, cmd_ready}, 32'd0);
        rst = 1'b0;
        tick();
        check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_data_in_valid", {31'd0, data_in_valid}, 32'd0);
        check("reset_data_in", {16'd0, data_in}, 32'd0);
        check("reset_rsp_data", rsp_data, 32'd0);

        // Stray result while idle must be ignored.
        data_out = 32'h1234; data_out_valid = 1'b1;
        tick();
        data_out_valid = 1'b0;
        tick();
        check("idle_stray_result_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("idle_stray_result_rsp_valid", {31'd0, rsp_valid}, 32'd0);

        // 3 * -2
        issue(16'h0003, 16'hFFFE, 1'b0, 1'b0, c0);
        push_rsp(32'hFFFFFFFA, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_b_strobe();
        respond(32'hFFFFFFFA, 1'b0, 1'b0, 3);
        check_latency(c0, 1, 3);

        // busy_out held for 5 cycles on entry to SEND_A
        busy_out = 1'b1;
        issue(16'h0010, 16'h0020, 1'b0, 1'b0, c0);
        push_rsp(32'h00000200, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) tick();
        busy_out = 1'b0;
        wait_b_strobe();
        respond(32'h00000200, 1'b1, 1'b0, 2);
        check_latency(c0, 6, 8);

        // Corrupted A parity, multiplier flags it
        issue(16'h0001, 16'h0005, 1'b1, 1'b0, c0);
        push_rsp(32'h00000005, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_b_strobe();
        respond(32'h00000005, 1'b0, 1'b1, 2);

        // Timeout with no result
        issue(16'h0007, 16'h0009, 1'b0, 1'b0, c0);
        push_rsp(32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_b_strobe();
        tick();
        n = 0;
        while (rsp_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("timeout_latency", n, TO);

        // Result on the expiry cycle wins
        issue(16'h0007, 16'h0009, 1'b0, 1'b0, c0);
        push_rsp(32'd63, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_b_strobe();
        tick();
        repeat (TO - 1) tick();
        data_out = 32'd63; data_out_parity = 1'b0; data_out_valid = 1'b1;
        tick();
        data_out_valid = 1'b0;
        check("expiry_result_rsp_valid", {31'd0, rsp_valid}, 32'd1);

        // Reset during WAIT_RES, late result ignored
        issue(16'h0004, 16'h0004, 1'b0, 1'b0, c0);
        wait_b_strobe();
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("abort_cmd_ready_in_reset", {31'd0, cmd_ready}, 32'd0);
        check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_data_in_valid", {31'd0, data_in_valid}, 32'd0);
        rst = 1'b0;
        tick();
        check("abort_cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
        tick();
        data_out = 32'd16; data_out_parity = 1'b1; data_out_valid = 1'b1;
        tick();
        data_out_valid = 1'b0;
        repeat (3) tick();
        check("abort_late_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_late_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("abort_rsp_data", rsp_data, 32'd0);

        // -32768 * -32768 with host back-pressure
        rsp_ready = 1'b0;
        issue(16'h8000, 16'h8000, 1'b0, 1'b0, c0);
        push_rsp(32'h40000000, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_b_strobe();
        respond(32'h40000000, 1'b1, 1'b0, 2);
        for (int i = 0; i < 10; i++) begin
            check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_rsp_data", rsp_data, 32'h40000000);
            check("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("accept_cmd_ready_next", {31'd0, cmd_ready}, 32'd1);
        check("accept_rsp_valid_low", {31'd0, rsp_valid}, 32'd0);

        // Wrong product from the multiplier
        issue(16'h8000, 16'h8000, 1'b0, 1'b0, c0);
        push_rsp(32'h40000001, 1'b0, 1'b0, 1'b0, CHK_EN);
        wait_b_strobe();
        respond(32'h40000001, 1'b0, 1'b0, 2);

        // Corrupted result parity
        issue(16'h0002, 16'h0002, 1'b0, 1'b0, c0);
        push_rsp(32'h00000004, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_b_strobe();
        respond(32'h00000004, 1'b0, 1'b0, 2);

        repeat (5) tick();
        check("operand_queue_drained", op_q.size(), 0);
        check("response_queue_drained", rsp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
